// File: rtl/tp_pingpong_buf.sv
// tp_pingpong_buf: double-buffered N x N transpose memory.
// One bank fills row-by-row while the other drains either column-by-column
// (transposed) or row-by-row (pass-through), selected per block.
module tp_pingpong_buf #(
  parameter int N = 8,
  parameter int W = 12
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  input  logic           in_transpose,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_data,
  output logic           out_first,
  output logic           out_last
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  // Element storage: mem[bank][row][col]. Plain registers, since the
  // transposed read needs a whole column in a single cycle.
  logic [W-1:0] mem [2][N][N];

  logic [1:0]    full_reg;
  logic [1:0]    tmode_reg;
  logic          wr_bank_reg;
  logic          rd_bank_reg;
  logic [AW-1:0] wr_row_reg;
  logic [AW-1:0] rd_vec_reg;

  logic wr_fire;
  logic rd_fire;
  logic rd_tmode;

  // A bank is only written while not full and only read while full, so the
  // two sides never touch the same bank in the same cycle.
  assign in_ready  = !full_reg[wr_bank_reg];
  assign out_valid = full_reg[rd_bank_reg];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign rd_tmode  = tmode_reg[rd_bank_reg];
  assign out_first = out_valid && (rd_vec_reg == '0);
  assign out_last  = out_valid && (rd_vec_reg == LAST_IDX);

  // Bank flags and pointers; clear flushes exactly like reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_reg    <= '0;
      tmode_reg   <= '0;
      wr_bank_reg <= 1'b0;
      rd_bank_reg <= 1'b0;
      wr_row_reg  <= '0;
      rd_vec_reg  <= '0;
    end else if (clear) begin
      full_reg    <= '0;
      tmode_reg   <= '0;
      wr_bank_reg <= 1'b0;
      rd_bank_reg <= 1'b0;
      wr_row_reg  <= '0;
      rd_vec_reg  <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_row_reg == '0) begin
          tmode_reg[wr_bank_reg] <= in_transpose;
        end
        if (wr_row_reg == LAST_IDX) begin
          full_reg[wr_bank_reg] <= 1'b1;
          wr_bank_reg           <= ~wr_bank_reg;
          wr_row_reg            <= '0;
        end else begin
          wr_row_reg <= wr_row_reg + AW'(1);
        end
      end
      if (rd_fire) begin
        if (rd_vec_reg == LAST_IDX) begin
          full_reg[rd_bank_reg] <= 1'b0;
          rd_bank_reg           <= ~rd_bank_reg;
          rd_vec_reg            <= '0;
        end else begin
          rd_vec_reg <= rd_vec_reg + AW'(1);
        end
      end
    end
  end

  // Row write into the bank being filled; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_fire && !clear) begin
      for (int c = 0; c < N; c++) begin
        mem[wr_bank_reg][wr_row_reg][c] <= in_data[c*W +: W];
      end
    end
  end

  // Output element k: column rd_vec (transposed) or row rd_vec (pass-through),
  // forced to zero while nothing is valid.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_out
      logic [W-1:0] elem;
      assign elem = rd_tmode ? mem[rd_bank_reg][gi][rd_vec_reg]
                             : mem[rd_bank_reg][rd_vec_reg][gi];
      assign out_data[gi*W +: W] = out_valid ? elem : '0;
    end
  endgenerate

endmodule

// File: tb/tb_tp_pingpong_buf.sv
// Testbench for tp_pingpong_buf: a block-queue reference model checks every
// output on every falling edge, while directed scenarios pin latency,
// stalls, reset and clear against hand-computed values.
module tb_tp_pingpong_buf;

  localparam int N = 8;
  localparam int W = 12;

  logic           clk;
  logic           reset;
  logic           clear;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic           in_transpose;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] out_data;
  logic           out_first;
  logic           out_last;

  int n_cmp = 0;
  int n_bad = 0;

  tp_pingpong_buf #(.N(N), .W(W)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_transpose(in_transpose),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_first(out_first), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: queue of completed blocks -------------
  logic [N*W-1:0] done_rows [$];
  bit             done_mode [$];
  logic [N*W-1:0] part_rows [$];
  bit             part_mode;
  int             rd_idx;
  int             blk_cnt;

  task automatic model_reset();
    done_rows.delete();
    done_mode.delete();
    part_rows.delete();
    part_mode = 1'b0;
    rd_idx    = 0;
  endtask

  initial begin
    model_reset();
    blk_cnt = 0;
  end

  always @(negedge clk) begin
    logic           e_ir, e_ov, e_first, e_last;
    logic [N*W-1:0] e_data;
    if (!reset) begin
      model_reset();
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_first", out_first, 1'b0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_out_data", out_data, '0);
    end else begin
      e_ir    = (done_mode.size() < 2);
      e_ov    = (done_mode.size() > 0);
      e_data  = '0;
      if (e_ov) begin
        for (int k = 0; k < N; k++) begin
          if (done_mode[0]) e_data[k*W +: W] = done_rows[k][rd_idx*W +: W];
          else              e_data[k*W +: W] = done_rows[rd_idx][k*W +: W];
        end
      end
      e_first = e_ov && (rd_idx == 0);
      e_last  = e_ov && (rd_idx == N - 1);
      chk("m_in_ready", in_ready, e_ir);
      chk("m_out_valid", out_valid, e_ov);
      chk("m_out_data", out_data, e_data);
      chk("m_out_first", out_first, e_first);
      chk("m_out_last", out_last, e_last);
      if (clear) begin
        model_reset();
      end else begin
        if (e_ov && out_ready) begin
          $display("rd blk=%0d vec=%0d mode=%0b data=%h", blk_cnt, rd_idx, done_mode[0], e_data);
          rd_idx++;
          if (rd_idx == N) begin
            for (int k = 0; k < N; k++) void'(done_rows.pop_front());
            void'(done_mode.pop_front());
            rd_idx = 0;
            blk_cnt++;
          end
        end
        if (in_valid && e_ir) begin
          if (part_rows.size() == 0) part_mode = in_transpose;
          part_rows.push_back(in_data);
          if (part_rows.size() == N) begin
            for (int k = 0; k < N; k++) done_rows.push_back(part_rows[k]);
            done_mode.push_back(part_mode);
            part_rows.delete();
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  function automatic logic [N*W-1:0] pat_row(input int r);
    logic [N*W-1:0] v;
    for (int c = 0; c < N; c++) v[c*W +: W] = W'(16 * r + c);
    return v;
  endfunction

  function automatic logic [N*W-1:0] pat_vec(input int j, input bit tr);
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = tr ? W'(16 * k + j) : W'(16 * j + k);
    return v;
  endfunction

  function automatic logic [N*W-1:0] rand_row();
    logic [N*W-1:0] v;
    for (int c = 0; c < N; c++) v[c*W +: W] = W'($urandom);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Writes the 16*r+c block into an empty buffer and checks latency and the
  // literal output values; called at 1 time unit after a rising edge.
  task automatic run_block(input bit tr);
    out_ready = 1'b1;
    for (int r = 0; r < N; r++) begin
      in_valid     = 1'b1;
      in_transpose = tr;
      in_data      = pat_row(r);
      chk("lat_early", out_valid, 1'b0);
      step();
    end
    in_valid = 1'b0;
    in_data  = '0;
    chk("lat_valid", out_valid, 1'b1);
    for (int j = 0; j < N; j++) begin
      chk(tr ? "tr_data" : "row_data", out_data, pat_vec(j, tr));
      chk("lit_first", out_first, j == 0);
      chk("lit_last", out_last, j == N - 1);
      step();
    end
    chk("blk_drained", out_valid, 1'b0);
  endtask

  // ---------------- directed scenarios -------------------------------------
  initial begin
    int             nvalid, first_v, last_v, acc, rd, guard;
    bit             v, a;
    logic [N*W-1:0] snap;

    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    in_transpose = 1'b0; out_ready = 1'b0;
    #1;
    chk("init_in_ready", in_ready, 1'b1);
    chk("init_out_valid", out_valid, 1'b0);
    @(posedge clk); step();
    reset = 1'b1;
    step();

    // Basic transpose, then row mode.
    run_block(1'b1);
    run_block(1'b0);

    // Back-to-back streaming, modes 1,0,1,0.
    nvalid = 0; first_v = -1; last_v = -1;
    out_ready = 1'b1;
    for (int i = 0; i < 48; i++) begin
      in_valid     = (i < 4 * N);
      in_transpose = ((i / N) % 2) == 0;
      in_data      = rand_row();
      if (i < 4 * N) chk("stream_in_ready", in_ready, 1'b1);
      if (out_valid) begin
        nvalid++;
        if (first_v < 0) first_v = i;
        last_v = i;
      end
      step();
    end
    in_valid = 1'b0;
    chk("stream_count", 32'(nvalid), 32'(4 * N));
    chk("stream_first", 32'(first_v), 32'(N));
    chk("stream_contig", 32'(last_v - first_v + 1), 32'(4 * N));

    // Backpressure: three blocks offered with out_ready low.
    out_ready = 1'b0; acc = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid     = 1'b1;
      in_transpose = 1'($urandom);
      in_data      = rand_row();
      if (in_ready) acc++;
      if (i >= 2 * N) chk("bp_full", in_ready, 1'b0);
      if (i == 2 * N) snap = out_data;
      step();
    end
    chk("bp_accepted", 32'(acc), 32'(2 * N));
    chk("bp_stable", out_data, snap);
    chk("bp_first_hold", out_first, 1'b1);
    out_ready = 1'b1; rd = 0; guard = 0;
    while ((acc < 3 * N || out_valid) && guard < 100) begin
      in_valid     = (acc < 3 * N);
      in_transpose = 1'($urandom);
      in_data      = rand_row();
      v = out_valid;
      a = in_valid && in_ready;
      step();
      guard++;
      if (a) acc++;
      if (v) begin
        rd++;
        if (rd <= N) chk("bp_ready_ret", in_ready, rd == N);
      end
    end
    in_valid = 1'b0;
    chk("bp_drain", 32'(rd), 32'(3 * N));
    chk("bp_guard", 32'(guard < 100), 32'd1);

    // Async reset with one full bank and three rows of the next.
    out_ready = 1'b0;
    for (int r = 0; r < N + 3; r++) begin
      in_valid = 1'b1; in_transpose = 1'b1; in_data = rand_row();
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk("async_in_ready", in_ready, 1'b1);
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_out_data", out_data, '0);
    step();
    reset = 1'b1;
    run_block(1'b1);

    // clear together with a valid row: that row is dropped.
    out_ready = 1'b0;
    for (int r = 0; r < N + 2; r++) begin
      in_valid = 1'b1; in_transpose = 1'b0; in_data = rand_row();
      step();
    end
    chk("pre_clr_valid", out_valid, 1'b1);
    clear = 1'b1; in_data = rand_row();
    step();
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_out_valid", out_valid, 1'b0);
    chk("clr_in_ready", in_ready, 1'b1);
    run_block(1'b1);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
